bg_tile_renderer: RTL and testbench

Background renderer that sits directly downstream of the VGA timing generator. It consumes drawX/drawY/hs/vs/active_nblank and turns each pixel coordinate into a world position using a per-frame horizontal scroll. It fetches the tile ID from an external synchronous tile-map ROM, then the 4-bit palette index from an external synchronous tile-pixel ROM. It emits 12-bit RGB with hs/vs/blank delayed to match.

---
 rtl/render_pkg.sv | 30 +++
 rtl/sync_delay.sv | 27 ++
 rtl/bg_tile_renderer.sv | 126 ++++++++++++
 tb/tb_bg_tile_renderer.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/render_pkg.sv
// rtl/render_pkg.sv - shared constants, palette and colour type for the background renderer
`timescale 1ns/1ps
package render_pkg;

  localparam int TILE_PX  = 16;
  localparam int PIPE_LAT = 5;

  localparam logic [11:0] SKY_RGB = 12'h6AF;

  // Entry 0 is never displayed: index 0 is transparent and shows the sky.
  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'hFFF, 12'hF00, 12'h0F0,
    12'h00F, 12'hFF0, 12'h0FF, 12'hF0F,
    12'h888, 12'h444, 12'hC60, 12'h6C0,
    12'h06C, 12'hC06, 12'h963, 12'h369
  };

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  function automatic rgb_t palette_lookup(input logic [3:0] idx);
    rgb_t c;
    c = (idx == 4'd0) ? SKY_RGB : PALETTE[idx];
    return c;
  endfunction

endpackage

// File: rtl/sync_delay.sv
// rtl/sync_delay.sv - fixed-depth shift register that keeps sync/blank aligned with pixel data
`timescale 1ns/1ps
module sync_delay #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= RESET_VAL;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/bg_tile_renderer.sv
// rtl/bg_tile_renderer.sv - scrolling tile background: map ROM, pixel ROM, palette, 5-clock pipeline
`timescale 1ns/1ps
module bg_tile_renderer
  import render_pkg::*;
#(
  parameter int MAP_W_TILES = 256,
  parameter int MAP_H_TILES = 30
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        blank_in,
  input  logic [9:0]  drawX,
  input  logic [9:0]  drawY,
  input  logic [11:0] scroll_x,
  input  logic        scroll_valid,
  output logic [12:0] map_addr,
  input  logic [7:0]  map_data,
  output logic [15:0] tile_addr,
  input  logic [3:0]  tile_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hs_out,
  output logic        vs_out,
  output logic        blank_out,
  output logic        frame_start
);

  localparam int       PX_BITS  = $clog2(TILE_PX);
  localparam int       COL_BITS = $clog2(MAP_W_TILES);
  localparam int       ROW_BITS = $clog2(MAP_H_TILES);
  localparam logic [7:0] COL_MASK = 8'(MAP_W_TILES - 1);

  logic [11:0] scroll_active;
  logic [11:0] scroll_pending;
  logic        pending;
  logic        vs_d;
  logic        frame_edge;

  // Frame boundary is the falling edge of vsync.
  assign frame_edge = vs_d & ~vs_in;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_d           <= 1'b1;
      scroll_active  <= '0;
      scroll_pending <= '0;
      pending        <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      vs_d <= vs_in;
      if (frame_edge) begin
        // A strobe landing on the boundary wins over anything queued.
        if (scroll_valid)
          scroll_active <= scroll_x;
        else if (pending)
          scroll_active <= scroll_pending;
        pending     <= 1'b0;
        frame_start <= 1'b1;
      end else begin
        frame_start <= 1'b0;
        if (scroll_valid) begin
          scroll_pending <= scroll_x;
          pending        <= 1'b1;
        end
      end
    end
  end

  logic [11:0]         world_x;
  logic [7:0]          tile_col;
  logic [ROW_BITS-1:0] tile_row;
  logic [12:0]         map_addr_next;

  assign world_x       = 12'({2'b00, drawX}) + scroll_active;
  assign tile_col      = world_x[11:PX_BITS] & COL_MASK;
  assign tile_row      = drawY[PX_BITS +: ROW_BITS];
  assign map_addr_next = (13'(tile_row) << COL_BITS) | 13'(tile_col);

  logic unused_draw_y;
  assign unused_draw_y = &{1'b0, drawY[9]};

  logic [3:0] px1, py1, px2, py2;
  logic [3:0] blank_pipe;
  rgb_t       rgb_q;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      map_addr   <= '0;
      tile_addr  <= '0;
      px1        <= '0;
      py1        <= '0;
      px2        <= '0;
      py2        <= '0;
      blank_pipe <= '0;
      rgb_q      <= '0;
    end else begin
      map_addr   <= map_addr_next;
      px1        <= world_x[3:0];
      py1        <= drawY[3:0];
      px2        <= px1;
      py2        <= py1;
      tile_addr  <= {map_data, py2, px2};
      blank_pipe <= {blank_pipe[2:0], blank_in};
      rgb_q      <= blank_pipe[3] ? palette_lookup(tile_data) : '0;
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

  sync_delay #(
    .WIDTH    (3),
    .DEPTH    (PIPE_LAT),
    .RESET_VAL(3'b110)
  ) u_sync_delay (
    .pixel_clk(pixel_clk),
    .reset_n  (reset_n),
    .d        ({hs_in, vs_in, blank_in}),
    .q        ({hs_out, vs_out, blank_out})
  );

endmodule

// File: tb/tb_bg_tile_renderer.sv
// tb/tb_bg_tile_renderer.sv - directed bench for bg_tile_renderer with behavioural map/pixel ROMs
`timescale 1ns/1ps
module tb_bg_tile_renderer;

  logic        pixel_clk = 1'b0;
  logic        reset_n;
  logic        hs_in, vs_in, blank_in;
  logic [9:0]  drawX, drawY;
  logic [11:0] scroll_x;
  logic        scroll_valid;
  logic [12:0] map_addr;
  logic [7:0]  map_data = 8'd0;
  logic [15:0] tile_addr;
  logic [3:0]  tile_data = 4'd0;
  logic [3:0]  red, green, blue;
  logic        hs_out, vs_out, blank_out, frame_start;

  logic [7:0]  map_id;
  int          total = 0;
  int          bad = 0;
  int          fs_count;

  wire [11:0] rgb = {red, green, blue};

  localparam logic [11:0] C_P1  = 12'hFFF;
  localparam logic [11:0] C_P5  = 12'hFF0;
  localparam logic [11:0] C_P7  = 12'hF0F;
  localparam logic [11:0] C_P15 = 12'h369;
  localparam logic [11:0] C_SKY = 12'h6AF;

  always #20 pixel_clk = ~pixel_clk;

  bg_tile_renderer dut (
    .pixel_clk   (pixel_clk),
    .reset_n     (reset_n),
    .hs_in       (hs_in),
    .vs_in       (vs_in),
    .blank_in    (blank_in),
    .drawX       (drawX),
    .drawY       (drawY),
    .scroll_x    (scroll_x),
    .scroll_valid(scroll_valid),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .tile_addr   (tile_addr),
    .tile_data   (tile_data),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hs_out      (hs_out),
    .vs_out      (vs_out),
    .blank_out   (blank_out),
    .frame_start (frame_start)
  );

  // Map ROM: every cell holds map_id. Pixel ROM: tile 1 is solid 5, tile 2 encodes px, others 0.
  always @(posedge pixel_clk) begin
    map_data <= map_id;
    if (tile_addr[15:8] == 8'd1)      tile_data <= 4'd5;
    else if (tile_addr[15:8] == 8'd2) tile_data <= tile_addr[3:0];
    else                              tile_data <= 4'd0;
  end

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic [7:0]  id;
    logic [12:0] exp_map;
    logic [15:0] exp_tile;
    logic [11:0] exp_rgb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{10'd0,   10'd0,   1'b1, 8'd1, 13'd0,    16'h0100, C_P5};
    vecs[1] = '{10'd39,  10'd21,  1'b1, 8'd2, 13'd258,  16'h0257, C_P7};
    vecs[2] = '{10'd639, 10'd479, 1'b1, 8'd2, 13'd7463, 16'h02FF, C_P15};
    vecs[3] = '{10'd16,  10'd16,  1'b1, 8'd3, 13'd257,  16'h0300, C_SKY};
    vecs[4] = '{10'd50,  10'd100, 1'b0, 8'd1, 13'd1539, 16'h0142, 12'h000};
    vecs[5] = '{10'd1,   10'd0,   1'b1, 8'd2, 13'd0,    16'h0201, C_P1};

    reset_n = 1'b0; hs_in = 1'b0; vs_in = 1'b0; blank_in = 1'b1;
    drawX = 10'd5; drawY = 10'd5; scroll_x = 12'd0; scroll_valid = 1'b0; map_id = 8'd1;
    repeat (3) step();
    chk("reset_rgb", 16'(rgb), 16'h0);
    chk("reset_hs", 16'(hs_out), 16'h1);
    chk("reset_vs", 16'(vs_out), 16'h1);
    chk("reset_blank", 16'(blank_out), 16'h0);
    chk("reset_fs", 16'(frame_start), 16'h0);
    chk("reset_map_addr", 16'(map_addr), 16'h0);
    chk("reset_tile_addr", tile_addr, 16'h0);

    hs_in = 1'b1; vs_in = 1'b1; blank_in = 1'b0;
    reset_n = 1'b1;
    step(); step();

    for (int i = 0; i < 6; i++) begin
      drawX = vecs[i].x; drawY = vecs[i].y; blank_in = vecs[i].blank; map_id = vecs[i].id;
      step();
      chk($sformatf("vec%0d_map_addr", i), 16'(map_addr), 16'(vecs[i].exp_map));
      step(); step();
      chk($sformatf("vec%0d_tile_addr", i), tile_addr, vecs[i].exp_tile);
      step(); step();
      chk($sformatf("vec%0d_rgb", i), 16'(rgb), 16'(vecs[i].exp_rgb));
    end

    // Single visible pixel with hs low: exact 5-clock latency and alignment.
    blank_in = 1'b0; map_id = 8'd1; drawX = 10'd0; drawY = 10'd0;
    repeat (6) step();
    blank_in = 1'b1; hs_in = 1'b0;
    step();
    blank_in = 1'b0; hs_in = 1'b1; drawX = 10'd1;
    step(); step(); step();
    chk("lat4_blank", 16'(blank_out), 16'h0);
    chk("lat4_hs", 16'(hs_out), 16'h1);
    step();
    chk("lat5_blank", 16'(blank_out), 16'h1);
    chk("lat5_hs", 16'(hs_out), 16'h0);
    chk("lat5_rgb", 16'(rgb), 16'(C_P5));
    step();
    chk("lat6_rgb", 16'(rgb), 16'h0);
    chk("lat6_blank", 16'(blank_out), 16'h0);

    // Mid-frame scroll request stays queued until vsync falls.
    drawX = 10'd0; drawY = 10'd0; blank_in = 1'b1;
    scroll_x = 12'd20; scroll_valid = 1'b1;
    step();
    scroll_valid = 1'b0; scroll_x = 12'd0;
    repeat (3) step();
    chk("midframe_hold", 16'(map_addr), 16'h0);
    vs_in = 1'b0;
    step();
    chk("fs_pulse", 16'(frame_start), 16'h1);
    fs_count = 0;
    vs_in = 1'b1;
    step();
    fs_count += int'(frame_start);
    chk("scroll20_map_addr", 16'(map_addr), 16'd1);
    step(); fs_count += int'(frame_start);
    step(); fs_count += int'(frame_start);
    chk("scroll20_tile_addr", tile_addr, 16'h0104);
    chk("fs_single", 16'(fs_count), 16'h0);

    // Strobe on the boundary cycle is applied to that frame directly.
    vs_in = 1'b0; scroll_x = 12'd100; scroll_valid = 1'b1;
    step();
    scroll_valid = 1'b0; scroll_x = 12'd0;
    chk("bypass_fs", 16'(frame_start), 16'h1);
    vs_in = 1'b1;
    step();
    chk("bypass_map_addr", 16'(map_addr), 16'd6);
    step(); step();
    chk("bypass_tile_addr", tile_addr, 16'h0104);
    vs_in = 1'b0;
    step();
    vs_in = 1'b1;
    step();
    chk("bypass_no_pending", 16'(map_addr), 16'd6);

    // World X wraps modulo 4096.
    scroll_x = 12'd4090; scroll_valid = 1'b1;
    step();
    scroll_valid = 1'b0;
    vs_in = 1'b0;
    step();
    vs_in = 1'b1; drawX = 10'd10; drawY = 10'd16;
    step();
    chk("wrap_map_addr", 16'(map_addr), 16'd256);
    step(); step();
    chk("wrap_tile_addr", tile_addr, 16'h0104);
    step(); step();
    chk("wrap_rgb", 16'(rgb), 16'(C_P5));

    // Asynchronous reset mid-line, then restart with scroll cleared.
    reset_n = 1'b0;
    #2;
    chk("async_rgb", 16'(rgb), 16'h0);
    chk("async_blank", 16'(blank_out), 16'h0);
    chk("async_hs", 16'(hs_out), 16'h1);
    chk("async_vs", 16'(vs_out), 16'h1);
    chk("async_map_addr", 16'(map_addr), 16'h0);
    chk("async_tile_addr", tile_addr, 16'h0);
    repeat (3) @(posedge pixel_clk);
    #1;
    reset_n = 1'b1;
    step();
    chk("rst_map_addr", 16'(map_addr), 16'd256);
    step(); step();
    chk("rst_tile_addr", tile_addr, 16'h010A);
    step();
    chk("rst_lat4_blank", 16'(blank_out), 16'h0);
    step();
    chk("rst_lat5_blank", 16'(blank_out), 16'h1);
    chk("rst_lat5_rgb", 16'(rgb), 16'(C_P5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
